// File: rtl/sdram_wr_packer.sv
// Feeds the SDRAM controller write FIFO: splits 32-bit stream words into
// low/high halfwords, issues the session load strobe, and zero-pads to a burst boundary on flush.
module sdram_wr_packer #(
  parameter int unsigned ASIZE       = 23,
  parameter int unsigned BURST       = 256,
  parameter int unsigned LOAD_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [ASIZE-1:0] BASE_ADDR,
  input  logic [31:0]      IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             FLUSH,
  output logic             FLUSH_DONE,
  output logic             BUSY,
  output logic [15:0]      WR_DATA,
  output logic             WR,
  input  logic             WR_FULL,
  output logic             WR_LOAD,
  output logic [ASIZE-1:0] WR_ADDR,
  output logic [8:0]       WR_LENGTH,
  output logic [15:0]      HW_COUNT
);

  localparam int unsigned LCW       = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYCLES - 1);
  localparam logic [8:0]  CNT_LAST  = 9'(BURST - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_PAD, S_FDONE} state_e;
  typedef enum logic [1:0] {H_EMPTY, H_LO, H_HI} hold_e;

  state_e           state_q, state_d;
  hold_e            hold_st_q, hold_st_d;
  logic [31:0]      hold_data_q, hold_data_d;
  logic [LCW-1:0]   load_cnt_q, load_cnt_d;
  logic             flush_q, flush_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [15:0]      hw_q, hw_d;
  logic [ASIZE-1:0] addr_q, addr_d;

  logic             wr_en;
  logic             accept;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      hold_st_q   <= H_EMPTY;
      hold_data_q <= 32'h0;
      load_cnt_q  <= '0;
      flush_q     <= 1'b0;
      cnt_q       <= 9'd0;
      hw_q        <= 16'd0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_st_q   <= hold_st_d;
      hold_data_q <= hold_data_d;
      load_cnt_q  <= load_cnt_d;
      flush_q     <= flush_d;
      cnt_q       <= cnt_d;
      hw_q        <= hw_d;
      addr_q      <= addr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    hold_st_d   = hold_st_q;
    hold_data_d = hold_data_q;
    load_cnt_d  = load_cnt_q;
    flush_d     = flush_q;
    cnt_d       = cnt_q;
    hw_d        = hw_q;
    addr_d      = addr_q;

    if (wr_en) begin
      hw_d  = hw_q + 16'd1;
      cnt_d = (cnt_q == CNT_LAST) ? 9'd0 : cnt_q + 9'd1;
    end

    // An accept in the high-half cycle refills the holding register directly
    if (accept) begin
      hold_data_d = IN_DATA;
      hold_st_d   = H_LO;
    end else if (wr_en && state_q == S_STREAM) begin
      hold_st_d = (hold_st_q == H_LO) ? H_HI : H_EMPTY;
    end

    if (FLUSH && state_q == S_STREAM) flush_d = 1'b1;

    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_LOAD: begin
        if (load_cnt_q == LOAD_LAST) state_d = S_STREAM;
        else                         load_cnt_d = load_cnt_q + LCW'(1);
      end
      // Look at the post-write holding state so FLUSH_DONE follows the last data write directly
      S_STREAM: begin
        if (flush_q && hold_st_d == H_EMPTY) state_d = (cnt_d == 9'd0) ? S_FDONE : S_PAD;
      end
      S_PAD: begin
        if (wr_en && cnt_d == 9'd0) state_d = S_FDONE;
      end
      S_FDONE: state_d = S_STREAM;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_FDONE) flush_d = 1'b0;

    if (START) begin
      state_d    = S_LOAD;
      load_cnt_d = '0;
      hold_st_d  = H_EMPTY;
      flush_d    = 1'b0;
      addr_d     = BASE_ADDR;
      cnt_d      = 9'd0;
      hw_d       = 16'd0;
    end
  end

  // Outputs; write strobe and ready depend combinationally on WR_FULL
  always_comb begin
    wr_en    = 1'b0;
    WR_DATA  = 16'h0000;
    IN_READY = 1'b0;

    if (state_q == S_STREAM) begin
      if (hold_st_q == H_LO)      WR_DATA = hold_data_q[15:0];
      else if (hold_st_q == H_HI) WR_DATA = hold_data_q[31:16];
      wr_en    = (hold_st_q != H_EMPTY) && !WR_FULL;
      IN_READY = !flush_q && ((hold_st_q == H_EMPTY) || (hold_st_q == H_HI && !WR_FULL));
    end else if (state_q == S_PAD) begin
      wr_en = !WR_FULL;
    end

    // A restart or reset cycle neither writes nor accepts
    if (RESET || START) begin
      wr_en    = 1'b0;
      IN_READY = 1'b0;
    end

    accept     = IN_VALID && IN_READY;
    WR         = wr_en;
    WR_LOAD    = (state_q == S_LOAD);
    FLUSH_DONE = (state_q == S_FDONE);
    BUSY       = (state_q == S_LOAD) || (state_q == S_PAD) || (state_q == S_FDONE) ||
                 (hold_st_q != H_EMPTY) || flush_q;
  end

  assign WR_ADDR   = addr_q;
  assign WR_LENGTH = 9'(BURST);
  assign HW_COUNT  = hw_q;

endmodule

// File: tb/tb_sdram_wr_packer.sv
// Directed self-checking bench for sdram_wr_packer (BURST=256, LOAD_CYCLES=2).
module tb_sdram_wr_packer;

  localparam int unsigned ASIZE = 23;

  logic             CLK = 1'b0;
  logic             RESET, START, FLUSH, IN_VALID, WR_FULL;
  logic [ASIZE-1:0] BASE_ADDR;
  logic [31:0]      IN_DATA;
  logic             IN_READY, FLUSH_DONE, BUSY, WR, WR_LOAD;
  logic [15:0]      WR_DATA, HW_COUNT;
  logic [ASIZE-1:0] WR_ADDR;
  logic [8:0]       WR_LENGTH;

  sdram_wr_packer #(.ASIZE(ASIZE), .BURST(256), .LOAD_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FLUSH(FLUSH), .FLUSH_DONE(FLUSH_DONE), .BUSY(BUSY),
    .WR_DATA(WR_DATA), .WR(WR), .WR_FULL(WR_FULL), .WR_LOAD(WR_LOAD),
    .WR_ADDR(WR_ADDR), .WR_LENGTH(WR_LENGTH), .HW_COUNT(HW_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [15:0] wq[$];
  int          wc[$];
  int          fd_cnt = 0;
  int          fd_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Capture FIFO writes and FLUSH_DONE pulses mid-cycle
  always @(negedge CLK) begin
    if (WR) begin
      wq.push_back(WR_DATA);
      wc.push_back(cyc);
    end
    if (FLUSH_DONE) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic do_start(input logic [ASIZE-1:0] a);
    START     = 1'b1;
    BASE_ADDR = a;
    tick();
    START = 1'b0;
  endtask

  // Offer one word, wait (bounded) for IN_READY, optionally pulse FLUSH with the accept
  task automatic send(input logic [31:0] d, input logic fl);
    int i;
    IN_DATA  = d;
    IN_VALID = 1'b1;
    #2;
    i = 0;
    while (!IN_READY && i < 50) begin
      tick();
      #2;
      i++;
    end
    if (!IN_READY) chk("send_ready_timeout", 32'(IN_READY), 32'd1);
    FLUSH = fl;
    tick();
    IN_VALID = 1'b0;
    FLUSH    = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    int i;
    i = 0;
    while (fd_cnt == 0 && i < budget) begin
      tick();
      i++;
    end
    chk("flush_done_seen", 32'(fd_cnt > 0), 32'd1);
  endtask

  function automatic logic [15:0] wq_at(input int i);
    return (i < wq.size()) ? wq[i] : 16'hDEAD;
  endfunction

  function automatic int last_wc();
    return (wc.size() > 0) ? wc[wc.size()-1] : -100;
  endfunction

  initial begin
    logic [15:0] exp4 [4];
    int nz;
    int bad;
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; WR_FULL = 1'b0;
    BASE_ADDR = '0; IN_DATA = 32'h0;

    // Reset values
    tick(); tick();
    #2;
    chk("rst_wr", 32'(WR), 32'd0);
    RESET = 1'b0;
    tick();
    #2;
    chk("rst_in_ready", 32'(IN_READY), 32'd0);
    chk("rst_wr_load", 32'(WR_LOAD), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_flush_done", 32'(FLUSH_DONE), 32'd0);
    chk("rst_wr_data", 32'(WR_DATA), 32'd0);
    chk("rst_hw_count", 32'(HW_COUNT), 32'd0);
    chk("rst_wr_addr", 32'(WR_ADDR), 32'd0);
    chk("wr_length", 32'(WR_LENGTH), 32'd256);
    tick();

    // Session start: WR_LOAD two cycles, ready on the third
    do_start(23'h1000);
    #2;
    chk("start_load_c1", 32'(WR_LOAD), 32'd1);
    chk("start_addr", 32'(WR_ADDR), 32'h1000);
    chk("start_rdy_c1", 32'(IN_READY), 32'd0);
    chk("start_busy", 32'(BUSY), 32'd1);
    tick(); #2;
    chk("start_load_c2", 32'(WR_LOAD), 32'd1);
    chk("start_rdy_c2", 32'(IN_READY), 32'd0);
    tick(); #2;
    chk("start_load_c3", 32'(WR_LOAD), 32'd0);
    chk("start_rdy_c3", 32'(IN_READY), 32'd1);
    tick();

    // Two words, no back-pressure
    wq.delete(); wc.delete();
    send(32'h11112222, 1'b0);
    send(32'h33334444, 1'b0);
    drain(4);
    exp4 = '{16'h2222, 16'h1111, 16'h4444, 16'h3333};
    chk("stream_n", 32'(wq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("stream_d%0d", i), 32'(wq_at(i)), 32'(exp4[i]));
    chk("stream_consec", 32'(last_wc() - ((wc.size() > 0) ? wc[0] : 0)), 32'd3);
    chk("stream_hw", 32'(HW_COUNT), 32'd4);

    // WR_FULL for 5 cycles with the low half pending
    wq.delete(); wc.delete();
    send(32'hAAAABBBB, 1'b0);
    WR_FULL  = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA  = 32'hCCCCDDDD;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("full_wr_c%0d", i), 32'(WR), 32'd0);
      chk($sformatf("full_rdy_c%0d", i), 32'(IN_READY), 32'd0);
      tick();
    end
    WR_FULL  = 1'b0;
    IN_VALID = 1'b0;
    drain(4);
    chk("full_n", 32'(wq.size()), 32'd2);
    chk("full_d0", 32'(wq_at(0)), 32'hBBBB);
    chk("full_d1", 32'(wq_at(1)), 32'hAAAA);
    chk("full_hw", 32'(HW_COUNT), 32'd6);

    // New session, 3 words, flush -> 250 pads
    do_start(23'h2000);
    #2;
    chk("s2_hw_zero", 32'(HW_COUNT), 32'd0);
    tick();
    send(32'h01020304, 1'b0);
    send(32'h05060708, 1'b0);
    send(32'h090A0B0C, 1'b0);
    drain(3);
    wq.delete(); wc.delete(); fd_cnt = 0;
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    wait_fd(300);
    drain(3);
    nz = 0;
    foreach (wq[i]) if (wq[i] != 16'h0) nz++;
    chk("pad_n", 32'(wq.size()), 32'd250);
    chk("pad_nonzero", 32'(nz), 32'd0);
    chk("pad_hw", 32'(HW_COUNT), 32'd256);
    chk("pad_fd_once", 32'(fd_cnt), 32'd1);
    chk("pad_fd_cycle", 32'(fd_cyc - last_wc()), 32'd1);
    #2;
    chk("pad_rdy_after", 32'(IN_READY), 32'd1);
    chk("pad_busy_after", 32'(BUSY), 32'd0);
    tick();

    // 128 words with FLUSH on the last accept: cnt lands on 0, no padding
    wq.delete(); wc.delete(); fd_cnt = 0;
    for (int i = 0; i < 128; i++) send({16'(i) | 16'h8000, 16'(i)}, (i == 127) ? 1'b1 : 1'b0);
    wait_fd(20);
    drain(3);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (wq_at(2*i) != 16'(i)) bad++;
      if (wq_at(2*i+1) != (16'(i) | 16'h8000)) bad++;
    end
    chk("nopad_n", 32'(wq.size()), 32'd256);
    chk("nopad_data_bad", 32'(bad), 32'd0);
    chk("nopad_fd_once", 32'(fd_cnt), 32'd1);
    chk("nopad_fd_cycle", 32'(fd_cyc - last_wc()), 32'd1);
    chk("nopad_hw", 32'(HW_COUNT), 32'd512);

    // FLUSH together with an accepted word: word first, then 254 pads
    wq.delete(); wc.delete(); fd_cnt = 0;
    send(32'hBEEFCAFE, 1'b1);
    wait_fd(300);
    drain(3);
    nz = 0;
    for (int i = 2; i < wq.size(); i++) if (wq[i] != 16'h0) nz++;
    chk("fw_n", 32'(wq.size()), 32'd256);
    chk("fw_d0", 32'(wq_at(0)), 32'hCAFE);
    chk("fw_d1", 32'(wq_at(1)), 32'hBEEF);
    chk("fw_pad_nonzero", 32'(nz), 32'd0);
    chk("fw_hw", 32'(HW_COUNT), 32'd768);
    chk("fw_fd_once", 32'(fd_cnt), 32'd1);

    // START in the middle of padding
    fd_cnt = 0;
    send(32'h12345678, 1'b1);
    drain(20);
    #2;
    chk("mid_pad_busy", 32'(BUSY), 32'd1);
    tick();
    wq.delete(); wc.delete();
    do_start(23'h3000);
    #2;
    chk("restart_load", 32'(WR_LOAD), 32'd1);
    chk("restart_wr", 32'(WR), 32'd0);
    chk("restart_hw", 32'(HW_COUNT), 32'd0);
    chk("restart_addr", 32'(WR_ADDR), 32'h3000);
    drain(10);
    #2;
    chk("restart_no_writes", 32'(wq.size()), 32'd0);
    chk("restart_no_fd", 32'(fd_cnt), 32'd0);
    chk("restart_rdy", 32'(IN_READY), 32'd1);
    chk("restart_busy", 32'(BUSY), 32'd0);
    tick();

    // RESET with a held word
    send(32'hFACEB00C, 1'b0);
    WR_FULL = 1'b1;
    tick();
    wq.delete(); wc.delete();
    RESET = 1'b1;
    #2;
    chk("mrst_wr_in_reset", 32'(WR), 32'd0);
    tick();
    RESET   = 1'b0;
    WR_FULL = 1'b0;
    #2;
    chk("mrst_in_ready", 32'(IN_READY), 32'd0);
    chk("mrst_wr", 32'(WR), 32'd0);
    chk("mrst_wr_load", 32'(WR_LOAD), 32'd0);
    chk("mrst_flush_done", 32'(FLUSH_DONE), 32'd0);
    chk("mrst_busy", 32'(BUSY), 32'd0);
    chk("mrst_wr_data", 32'(WR_DATA), 32'd0);
    chk("mrst_hw", 32'(HW_COUNT), 32'd0);
    chk("mrst_addr", 32'(WR_ADDR), 32'd0);
    tick();
    drain(5);
    chk("mrst_no_writes", 32'(wq.size()), 32'd0);
    do_start(23'h4000);
    #2;
    chk("mrst_load_c1", 32'(WR_LOAD), 32'd1);
    chk("mrst_addr_new", 32'(WR_ADDR), 32'h4000);
    tick(); #2;
    chk("mrst_load_c2", 32'(WR_LOAD), 32'd1);
    tick(); #2;
    chk("mrst_load_c3", 32'(WR_LOAD), 32'd0);
    chk("mrst_rdy_c3", 32'(IN_READY), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
